if_fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC, issues requests to a variable-latency instruction memory
//  and presents one fetched instruction to the IF/ID register. It consumes the branch redirect
//  (Br_taken/Br_Addr) produced by the execute stage, discards wrong-path fetches and flushes
//  the front end. Honours the hazard unit's freeze.

---
 rtl/if_fetch_stage_if.sv | 12 +
 rtl/if_fetch_stage.sv | 154 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the
// instruction memory (slave). req/addr are held by the master until the
// slave pulses ready for one cycle with rdata valid in that same cycle.
interface if_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to a
// variable-latency instruction memory, buffers a single fetched instruction
// for IF/ID, and handles branch redirects by discarding wrong-path fetches.
// Optional feature macro: IF_PERF_CNT_EN builds the fetch/kill counters;
// without it perf_fetch/perf_kill are tied to zero.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               Br_taken,
    input  logic [31:0]        Br_Addr,
    if_fetch_stage_if.master   imem,
    output logic               if_valid,
    output logic [31:0]        Instruction,
    output logic [31:0]        PC,
    output logic               flush,
    output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_kill
);

    // IDLE: nothing outstanding; REQ: useful request outstanding;
    // KILL: wrong-path request outstanding, its data will be dropped.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        issue;
    logic [31:0] pc;
    logic [31:0] pend;
    logic [31:0] br_target;
    logic        consumed;
    logic        buf_free;
    logic        done_useful;
    logic        done_kill;

    // Redirect targets are always word aligned.
    assign br_target   = {Br_Addr[31:2], 2'b00};
    assign flush       = Br_taken;
    assign consumed    = if_valid & ~freeze;
    assign buf_free    = ~if_valid | consumed;
    assign done_useful = (state == REQ) & imem.ready & ~Br_taken;
    assign done_kill   = ((state == REQ) & imem.ready & Br_taken) |
                         ((state == KILL) & imem.ready);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and request-issue decision.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned,
        // which would otherwise infer a latch.
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (!Br_taken && buf_free) begin
                    state_nxt = REQ;
                    issue     = 1'b1;
                end
            end
            REQ: begin
                if (imem.ready)    state_nxt = IDLE;
                else if (Br_taken) state_nxt = KILL;
            end
            KILL: begin
                if (imem.ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // PC, pending redirect target and the registered memory request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            pend      <= 32'h0;
            imem.req  <= 1'b0;
            imem.addr <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (Br_taken) begin
                        pc <= br_target;
                    end else if (issue) begin
                        imem.req  <= 1'b1;
                        imem.addr <= pc;
                    end
                end
                REQ: begin
                    if (imem.ready) begin
                        imem.req <= 1'b0;
                        pc       <= Br_taken ? br_target : pc + 32'd4;
                    end else if (Br_taken) begin
                        pend <= br_target;
                    end
                end
                KILL: begin
                    if (imem.ready) begin
                        imem.req <= 1'b0;
                        pc       <= Br_taken ? br_target : pend;
                    end else if (Br_taken) begin
                        pend <= br_target;
                    end
                end
                default: ;
            endcase
        end
    end

    // One-entry output buffer; a redirect empties it ahead of hold or load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid    <= 1'b0;
            Instruction <= 32'h0;
            PC          <= 32'h0;
        end else if (Br_taken) begin
            if_valid <= 1'b0;
        end else if (done_useful) begin
            if_valid    <= 1'b1;
            Instruction <= imem.rdata;
            PC          <= pc + 32'd4;
        end else if (consumed) begin
            if_valid <= 1'b0;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Useful and discarded completion counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch <= 32'h0;
            perf_kill  <= 32'h0;
        end else begin
            if (done_useful) perf_fetch <= perf_fetch + 32'd1;
            if (done_kill)   perf_kill  <= perf_kill + 32'd1;
        end
    end
`else
    assign perf_fetch = 32'h0;
    assign perf_kill  = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a variable-latency memory model answers requests
// with an address-derived word; a program-flow model (sequential addresses,
// restarted at each redirect or reset) fills an expectation queue that a
// separate monitor pops every time IF/ID consumes an instruction.
module tb_if_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        Br_taken;
    logic [31:0] Br_Addr;
    logic        if_valid;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic        flush;
    logic [31:0] perf_fetch;
    logic [31:0] perf_kill;

    if_fetch_stage_if imem ();

    if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .Br_taken    (Br_taken),
        .Br_Addr     (Br_Addr),
        .imem        (imem),
        .if_valid    (if_valid),
        .Instruction (Instruction),
        .PC          (PC),
        .flush       (flush),
        .perf_fetch  (perf_fetch),
        .perf_kill   (perf_kill)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          lat = 1;
    int          mem_cnt = 0;
    int          consumed_n = 0;
    int          consumed_total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] tail_pc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Program-flow model: next instructions are sequential from tail_pc.
    task automatic refill();
        while (exp_q.size() < 2) begin
            exp_q.push_back(tail_pc);
            tail_pc = tail_pc + 32'd4;
        end
    endtask

    task automatic model_restart(input logic [31:0] a);
        exp_q.delete();
        tail_pc = {a[31:2], 2'b00};
        refill();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        Br_taken = 1'b0;
        refill();
    endtask

    task automatic do_branch(input logic [31:0] a);
        Br_taken = 1'b1;
        Br_Addr  = a;
        model_restart(a);
    endtask

    task automatic wait_req(output logic [31:0] a, output bit ok);
        bit prev;
        prev = imem.req;
        ok   = 1'b0;
        a    = 32'h0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (imem.req && !prev) begin
                a  = imem.addr;
                ok = 1'b1;
                break;
            end
            prev = imem.req;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL wait_req: no new request within 64 cycles (t=%0t)", $time);
        end
    endtask

    task automatic expect_req(input string name, input logic [31:0] exp);
        logic [31:0] a;
        bit          ok;
        wait_req(a, ok);
        if (ok) check(name, a, exp);
    endtask

    // Instruction memory: ready after 'lat' request cycles, one-cycle pulse.
    initial begin
        imem.ready = 1'b0;
        imem.rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                imem.ready = 1'b0;
                mem_cnt    = 0;
            end else if (imem.ready) begin
                imem.ready = 1'b0;
                imem.rdata = $urandom;
            end else if (imem.req) begin
                mem_cnt++;
                if (mem_cnt >= lat) begin
                    imem.ready = 1'b1;
                    imem.rdata = word_of(imem.addr);
                    mem_cnt    = 0;
                end
            end
        end
    end

    // Monitor: protocol invariants plus scoreboard pop on each consumption.
    initial begin
        bit          prev_wait;
        bit          prev_hold;
        logic [31:0] prev_addr;
        logic [31:0] prev_ins;
        logic [31:0] prev_pc;
        logic [31:0] e;
        prev_wait = 1'b0;
        prev_hold = 1'b0;
        prev_addr = 32'h0;
        prev_ins  = 32'h0;
        prev_pc   = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_wait  = 1'b0;
                prev_hold  = 1'b0;
                consumed_n = 0;
            end else begin
                check("flush", {31'h0, flush}, {31'h0, Br_taken});
                check("valid_and_req", {31'h0, if_valid & imem.req}, 32'h0);
                if (imem.req) check("addr_align", {30'h0, imem.addr[1:0]}, 32'h0);
                if (prev_wait) begin
                    check("req_held", {31'h0, imem.req}, 32'h1);
                    check("addr_stable", imem.addr, prev_addr);
                end
                if (prev_hold) begin
                    check("hold_valid", {31'h0, if_valid}, 32'h1);
                    check("hold_instr", Instruction, prev_ins);
                    check("hold_pc", PC, prev_pc);
                end
                if (if_valid && !freeze && !Br_taken) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL scoreboard: consumption with empty queue (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("pc", PC, e + 32'd4);
                        check("instr", Instruction, word_of(e));
                        consumed_n++;
                        consumed_total++;
                    end
                end
                prev_wait = imem.req && !imem.ready;
                prev_addr = imem.addr;
                prev_hold = if_valid && freeze && !Br_taken;
                prev_ins  = Instruction;
                prev_pc   = PC;
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] s_ins;
        logic [31:0] s_pc;
        logic [31:0] kill0;
        bit          ok;
        bit          hit;
        bit          prev_br;

        rst      = 1'b1;
        freeze   = 1'b0;
        Br_taken = 1'b0;
        Br_Addr  = 32'h0;
        model_restart(RESET_PC);

        // Reset values.
        #2;
        check("rst_req", {31'h0, imem.req}, 32'h0);
        check("rst_addr", imem.addr, 32'h0);
        check("rst_valid", {31'h0, if_valid}, 32'h0);
        check("rst_instr", Instruction, 32'h0);
        check("rst_pc", PC, 32'h0);
        check("rst_perf_fetch", perf_fetch, 32'h0);
        check("rst_perf_kill", perf_kill, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Sequential fetch with single-cycle memory.
        lat = 1;
        expect_req("seq0", RESET_PC);
        expect_req("seq1", RESET_PC + 32'h4);
        expect_req("seq2", RESET_PC + 32'h8);

        // Freeze holds the buffer and blocks new requests.
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if_valid) begin hit = 1'b1; break; end
            step();
        end
        check("freeze_got_valid", {31'h0, hit}, 32'h1);
        freeze = 1'b1;
        s_ins  = Instruction;
        s_pc   = PC;
        repeat (5) begin
            step();
            check("freeze_instr", Instruction, s_ins);
            check("freeze_pc", PC, s_pc);
            check("freeze_noreq", {31'h0, imem.req}, 32'h0);
        end
        freeze = 1'b0;
        expect_req("freeze_resume", s_pc);

        // Redirect while IDLE with a frozen full buffer; low bits dropped.
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if_valid) begin hit = 1'b1; break; end
            step();
        end
        freeze = 1'b1;
        do_branch(32'h0000_0203);
        step();
        freeze = 1'b0;
        check("idle_br_valid", {31'h0, if_valid}, 32'h0);
        expect_req("idle_br_target", 32'h0000_0200);

        // Redirect in first cycle of a 3-cycle request.
        lat = 3;
        wait_req(a, ok);
        kill0 = perf_kill;
        do_branch(32'h0000_0400);
        expect_req("req_br_target", 32'h0000_0400);
`ifdef IF_PERF_CNT_EN
        check("perf_kill_delta", perf_kill - kill0, 32'h1);
`endif

        // Redirect coincident with ready.
        wait_req(a, ok);
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (imem.ready) begin hit = 1'b1; break; end
            step();
        end
        check("coinc_saw_ready", {31'h0, hit}, 32'h1);
        do_branch(32'h0000_04A0);
        expect_req("coinc_br_target", 32'h0000_04A0);

        // Two redirects while KILL: last one wins.
        lat = 4;
        wait_req(a, ok);
        do_branch(32'h0000_0500);
        step();
        step();
        do_branch(32'h0000_0600);
        expect_req("kill_last_wins", 32'h0000_0600);

        // Asynchronous reset in the middle of a request.
        wait_req(a, ok);
        #3;
        rst = 1'b1;
        model_restart(RESET_PC);
        #1;
        check("async_rst_req", {31'h0, imem.req}, 32'h0);
        check("async_rst_addr", imem.addr, 32'h0);
        check("async_rst_valid", {31'h0, if_valid}, 32'h0);
        check("async_rst_pc", PC, 32'h0);
        step();
        step();
        rst = 1'b0;
        lat = 1;
        expect_req("restart_pc", RESET_PC);

        // Randomized traffic, including redirects near the top of memory.
        prev_br = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (!imem.req && $urandom_range(0, 7) == 0) lat = $urandom_range(1, 4);
            freeze = ($urandom_range(0, 9) < 3);
            if (!prev_br && $urandom_range(0, 11) == 0) begin
                if ($urandom_range(0, 3) == 0) do_branch(32'hFFFF_FFF0 + $urandom_range(0, 15));
                else                           do_branch($urandom);
                prev_br = 1'b1;
            end else begin
                prev_br = 1'b0;
            end
        end
        freeze = 1'b0;
        repeat (20) step();
        check("progress", {31'h0, consumed_total > 200}, 32'h1);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch_covers", {31'h0, perf_fetch >= consumed_n}, 32'h1);
`else
        check("perf_fetch_tied", perf_fetch, 32'h0);
        check("perf_kill_tied", perf_kill, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
